// File: rtl/serial_twos_complement_if.sv
// Handshake bundle for the bit-serial two's-complement unit: operand side in, result side out.
interface serial_twos_complement_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/serial_twos_complement.sv
// Bit-serial pass / negate / abs / sign-magnitude converter, LSB first, one bit per clock.
// Result is -operand mod 2^WIDTH via copy-through-first-one, invert-after.
module serial_twos_complement #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_twos_complement_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  logic             neg;
  logic             ovf_r;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] operand_in;
  logic             neg_in;
  logic             bit_in;
  logic             bit_out;
  logic             last_bit;

  always_comb begin
    operand_in = bus.in_data;
    neg_in     = 1'b0;
    case (bus.in_mode)
      2'b00:   neg_in = 1'b0;
      2'b01:   neg_in = 1'b1;
      2'b10:   neg_in = bus.in_data[WIDTH-1];
      default: begin
        neg_in                = bus.in_data[WIDTH-1];
        operand_in[WIDTH-1]   = 1'b0;
      end
    endcase
  end

  // work shifts right; processed bits enter at the top, so after WIDTH shifts it holds the result
  always_comb begin
    bit_in   = work[0];
    bit_out  = (neg && seen_one) ? ~bit_in : bit_in;
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (last_bit)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      seen_one   <= 1'b0;
      neg        <= 1'b0;
      work       <= '0;
      out_data_r <= '0;
      ovf_r      <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      work     <= operand_in;
      neg      <= neg_in;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (state == BUSY) begin
      work     <= {bit_out, work[WIDTH-1:1]};
      seen_one <= seen_one | bit_in;
      cnt      <= cnt + CW'(1);
      // Overflow only when negating MIN: no one below the MSB, and the MSB itself is one
      if (last_bit) begin
        out_data_r <= {bit_out, work[WIDTH-1:1]};
        ovf_r      <= neg & ~seen_one & bit_in;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = ovf_r;
endmodule

// File: tb/tb_serial_twos_complement.sv
// Randomised and directed checks of serial_twos_complement against an arithmetic reference model.
module tb_serial_twos_complement;
  localparam int W  = 8;
  localparam int W4 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_twos_complement_if #(.WIDTH(W))  bus8 ();
  serial_twos_complement_if #(.WIDTH(W4)) bus4 ();

  serial_twos_complement #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_twos_complement #(.WIDTH(W4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Returns {ovf, data} straight from the arithmetic meaning of each mode
  function automatic logic [W:0] ref_model(input logic [1:0] mode, input logic [W-1:0] x);
    logic [W-1:0] minv;
    logic [W-1:0] mag;
    logic [W-1:0] res;
    logic         ovf;
    minv = {1'b1, {(W-1){1'b0}}};
    mag  = x & ~minv;
    res  = x;
    ovf  = 1'b0;
    case (mode)
      2'd0: res = x;
      2'd1: begin res = W'(0) - x; ovf = (x == minv); end
      2'd2: if (x[W-1]) begin res = W'(0) - x; ovf = (x == minv); end
      default: if (x[W-1]) res = W'(0) - mag;
    endcase
    return {ovf, res};
  endfunction

  task automatic applyStimulus(input logic [1:0] mode, input logic [W-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.in_data  = data;
    bus8.in_mode  = mode;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic run_op8(input logic [1:0] mode, input logic [W-1:0] data, input int bp, input bit scramble);
    logic [W:0] exp;
    int         n = 0;
    exp = ref_model(mode, data);
    bus8.out_ready = (bp == 0);
    applyStimulus(mode, data);
    while (!bus8.out_valid && n < W + 5) begin
      if (scramble) begin
        bus8.in_valid = 1'($urandom);
        bus8.in_data  = W'($urandom);
        bus8.in_mode  = 2'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus8.in_valid = 1'b0;
    checkOutput("latency", 32'(n), 32'(W));
    checkOutput("out_data", 32'(bus8.out_data), 32'(exp[W-1:0]));
    checkOutput("out_ovf", 32'(bus8.out_ovf), 32'(exp[W]));
    checkOutput("done_in_ready", 32'(bus8.in_ready), 32'd0);
    checkOutput("done_busy", 32'(bus8.busy), 32'd1);
    for (int i = 0; i < bp; i++) begin
      bus8.in_valid = 1'($urandom);
      bus8.in_data  = W'($urandom);
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 32'(bus8.out_valid), 32'd1);
      checkOutput("bp_data", 32'(bus8.out_data), 32'(exp[W-1:0]));
      checkOutput("bp_ovf", 32'(bus8.out_ovf), 32'(exp[W]));
      checkOutput("bp_in_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("xfer_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("xfer_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("xfer_busy", 32'(bus8.busy), 32'd0);
    checkOutput("xfer_hold_data", 32'(bus8.out_data), 32'(exp[W-1:0]));
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W:0]   exp_q[$];
    int           acc_q[$];
    int           sent;
    int           recv;
    int           cyc;
    int           last_acc;
    int           n;
    logic [W-1:0] x;
    logic [3:0]   v4_in  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1010, 4'b1100, 4'b0000, 4'b1111};
    logic [3:0]   v4_out [8] = '{4'b1110, 4'b1100, 4'b1000, 4'b1010, 4'b0110, 4'b0100, 4'b0000, 4'b0001};

    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_mode = '0; bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = '0; bus4.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_out_data", 32'(bus8.out_data), 32'd0);
    checkOutput("rst_out_ovf", 32'(bus8.out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners for abs, sign-magnitude, pass and zero
    run_op8(2'd2, 8'hF6, 0, 1'b0);
    run_op8(2'd2, 8'h35, 0, 1'b0);
    run_op8(2'd2, 8'h80, 0, 1'b0);
    run_op8(2'd3, 8'h85, 0, 1'b0);
    run_op8(2'd3, 8'h05, 0, 1'b0);
    run_op8(2'd3, 8'h80, 0, 1'b0);
    run_op8(2'd0, 8'hA5, 0, 1'b0);
    run_op8(2'd1, 8'h00, 0, 1'b0);
    run_op8(2'd1, 8'h5A, 10, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_op8(2'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Streaming negation with both handshakes held open
    bus8.out_ready = 1'b1;
    sent = 0; recv = 0; cyc = 0; last_acc = 0;
    while (recv < 20 && cyc < 20 * (W + 2) + 50) begin
      @(negedge clk);
      cyc++;
      if (bus8.out_valid) begin
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          n   = acc_q.pop_front();
          checkOutput("stream_data", 32'(bus8.out_data), 32'(exp[W-1:0]));
          checkOutput("stream_ovf", 32'(bus8.out_ovf), 32'(exp[W]));
          checkOutput("stream_latency", 32'(cyc - n), 32'(W + 1));
        end else begin
          checkOutput("stream_spurious", 32'd1, 32'd0);
        end
        recv++;
      end
      if (bus8.in_ready && sent < 20) begin
        x = W'($urandom);
        bus8.in_valid = 1'b1;
        bus8.in_data  = x;
        bus8.in_mode  = 2'd1;
        exp_q.push_back(ref_model(2'd1, x));
        acc_q.push_back(cyc);
        if (sent > 0) checkOutput("stream_period", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        sent++;
      end else if (sent >= 20) begin
        bus8.in_valid = 1'b0;
      end
    end
    bus8.in_valid = 1'b0;
    checkOutput("stream_count", 32'(recv), 32'd20);
    bus8.out_ready = 1'b0;

    // Leave a nonzero overflowing result registered, then abort the next operation
    run_op8(2'd1, 8'h80, 0, 1'b0);
    applyStimulus(2'd1, 8'h3C);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus8.busy), 32'd0);
    checkOutput("abort_out_data", 32'(bus8.out_data), 32'd0);
    checkOutput("abort_out_ovf", 32'(bus8.out_ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) n++;
    end
    checkOutput("abort_never_valid", 32'(n), 32'd0);
    run_op8(2'd2, 8'hF6, 0, 1'b0);

    // Four-bit instance with the original negator's vectors
    for (int i = 0; i < 8; i++) begin
      n = 0;
      @(negedge clk);
      while (!bus4.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("w4_accept_ready", 32'(bus4.in_ready), 32'd1);
      bus4.in_valid  = 1'b1;
      bus4.in_data   = v4_in[i];
      bus4.in_mode   = 2'd1;
      bus4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < W4 + 5) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("w4_latency", 32'(n), 32'(W4));
      checkOutput("w4_out_data", 32'(bus4.out_data), 32'(v4_out[i]));
      checkOutput("w4_out_ovf", 32'(bus4.out_ovf), 32'(v4_in[i] == 4'b1000));
      @(posedge clk);
      #1;
      checkOutput("w4_xfer_in_ready", 32'(bus4.in_ready), 32'd1);
      bus4.out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_twos_complement.md
# serial_twos_complement

Parametrised, bit-serial two's-complement conversion unit with valid/ready handshakes on input and output. It accepts one WIDTH-bit operand plus a 2-bit mode, processes it LSB-first at one bit per clock, and returns the result with an overflow flag. It generalises the team's 4-bit combinational negator to any width, adds absolute-value and sign-magnitude conversion modes, and sits between register-sliced datapath stages that tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and mode presented.
- in_ready  output  1  unit can accept; equals (state == IDLE).
- in_data  input  WIDTH  operand.
- in_mode  input  2  operation mode; 00 pass, 01 negate, 10 absolute value, 11 sign-magnitude to two's complement.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result not representable; qualified by out_valid.
- busy  output  1  high in BUSY or DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when in_valid && in_ready. in_data and in_mode are latched, the bit counter is cleared, and seen_one is cleared.
  - BUSY: one bit is processed per cycle, LSB first. The state moves to DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE when out_valid && out_ready. DONE holds indefinitely while out_ready is low.
- neg flag, fixed at acceptance:
  - mode 00: 0.
  - mode 01: 1.
  - mode 10 or 11: in_data[WIDTH-1].
- Operand: in_data for modes 00, 01 and 10. For mode 11 it is in_data with the MSB cleared (the magnitude field).
- Per-bit rule for operand bit b:
  - result bit = neg ? (seen_one ? ~b : b) : b.
  - Then seen_one |= b.
  - This is copy-through-first-one, invert-after, so the result equals -operand modulo 2^WIDTH.
- out_ovf = 1 only for mode 01 or 10 when in_data == MIN, where MIN is 1 followed by WIDTH-1 zeros. In that case out_data = MIN.
- Mode 11 never overflows. Negative zero (MIN) converts to 0 with out_ovf = 0.
- Mode 00 returns the operand unchanged with out_ovf = 0.
- Zero negates to zero with out_ovf = 0.
- in_data and in_mode are ignored outside the IDLE acceptance cycle. Changes during BUSY or DONE have no effect.
- out_data and out_ovf hold stable throughout DONE. They retain their last value after the transfer until the next DONE.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, out_ovf = 0.
  - Internal counter and seen_one = 0.
- Acceptance edge E:
  - Bits 0..WIDTH-1 are processed on edges E+1 .. E+WIDTH.
  - out_valid rises after edge E+WIDTH.
- If out_ready is already high in DONE, the transfer occurs on edge E+WIDTH+1 and in_ready rises after that edge.
- Maximum throughput is one operation per WIDTH+2 cycles.
- in_ready is low from the cycle after acceptance until the cycle after the output transfer. There is no overlap between output transfer and new acceptance.
- Back-pressure: out_ready may stay low for any number of cycles. out_valid stays high, and out_data and out_ovf stay constant, until the transfer.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. The pending result is discarded, never presented, and all outputs return to their reset values.
- in_valid asserted while in_ready is low is not accepted and is not queued.
- The counter width is clog2(WIDTH). The counter wraps to 0 on entry to BUSY only.

## Test plan
- WIDTH=4, mode 01, in_data 0010, 0100, 1000, 0110, 1010, 1100, 0000, 1111 -> out_data 1110, 1100, 1000, 1010, 0110, 0100, 0000, 0001. out_ovf is 1 only for 1000. out_valid arrives exactly 4 cycles after each acceptance.
- WIDTH=8, mode 10: in_data 0xF6 -> out_data 0x0A, out_ovf 0. in_data 0x35 -> out_data 0x35. in_data 0x80 -> out_data 0x80, out_ovf 1.
- WIDTH=8, mode 11: in_data 0x85 -> out_data 0xFB. in_data 0x05 -> out_data 0x05. in_data 0x80 -> out_data 0x00, out_ovf 0. Mode 00 with in_data 0xA5 -> 0xA5.
- Back-pressure: hold out_ready low 10 cycles after out_valid -> out_valid, out_data and out_ovf remain constant and in_ready stays low. A toggling in_valid with changing in_data/in_mode during BUSY does not alter the result.
- Streaming: in_valid and out_ready held high with 20 random operands -> one result per WIDTH+2 cycles, all results matching a (-x mod 2^WIDTH) reference model.
- Reset mid-BUSY (rst_n low 2 cycles after acceptance) -> out_valid never rises for that operand, outputs take their reset values immediately, and the next operand after reset completes correctly.
